chip8_reg_exec: RTL and testbench
=================================

# chip8_reg_exec

Parametrised register-operation execution unit for the Chip-8 CPU. It contains the V-register file and executes the load/ALU instruction group (6xkk, 7xkk, 8xy0–8xyE), including VF flag generation. It uses a valid/ready instruction handshake with a done pulse, and provides registered debug read ports. It sits between the fetch/decode logic and the register file, replacing ad-hoc register writes in the CPU top.

## Interface
Parameters:
- DATA_W, 8, width of each V register; immediate kk is zero-extended to DATA_W
- NREGS, 16, number of V registers, 2..16; flag register is index NREGS-1 (VF when 16)

Ports:
- cpu_clk  in  1  sole clock, all state on rising edge
- cpu_rst_n  in  1  asynchronous active-low reset
- instr  in  16  Chip-8 instruction word
- instr_valid  in  1  instr is present
- instr_ready  out  1  unit can accept; high only in IDLE
- done  out  1  one-cycle pulse at instruction completion
- illegal  out  1  valid with done; instruction not in supported group or register index ≥ NREGS
- dbg_addr1, dbg_addr2  in  4 each  debug read register indices
- dbg_data1, dbg_data2  out  DATA_W each  registered debug read data

## Operation
- Reset: all V registers 0, state IDLE, instr_ready=1, done=0, illegal=0, dbg_data1/2=0.
- FSM states: IDLE → EXEC → FLAG → DONE → IDLE. FLAG is skipped for non-flag ops and for illegal ops.
- IDLE: on instr_valid & instr_ready, latch opcode, x=instr[11:8], y=instr[7:4], kk=instr[7:0], and current Vx and Vy values. Go to EXEC.
- EXEC: compute the result, write Vx (no write if illegal), compute the flag.
- Supported ops (result → Vx; flag → VF):
  - 6xkk: kk
  - 7xkk: Vx+kk modulo 2^DATA_W; no flag
  - 8xy0: Vy
  - 8xy1: OR
  - 8xy2: AND
  - 8xy3: XOR
  - 8xy4: Vx+Vy; flag = carry out of bit DATA_W-1
  - 8xy5: Vx−Vy; flag = 1 when Vx ≥ Vy
  - 8xy6: shift right by 1; flag = shifted-out LSB
  - 8xy7: Vy−Vx; flag = 1 when Vy ≥ Vx
  - 8xyE: shift left by 1; flag = shifted-out MSB
- Flag values are 0 or 1, zero-extended to DATA_W.
- Any other opcode (8xy8–8xyD, 8xyF, other top nibbles) or x/y ≥ NREGS: illegal, no register write.
- FLAG: write VF with the flag. Because this write is later than the Vx write, when x = NREGS-1 the flag overwrites the result.
- DONE: done=1; illegal=1 if applicable; instr_ready=0. Return to IDLE.
- Debug: each cycle, dbg_dataN <= V[dbg_addrN]; an index ≥ NREGS reads 0.
- instr_valid while not ready is ignored; the instruction is not queued.

## Timing
- Accept at edge N.
- Vx written at edge N+1.
- Flag ops: VF written at edge N+2; done high in cycle N+2..N+3; instr_ready high again from edge N+3.
- Non-flag/illegal ops: done high in cycle N+1..N+2; next accept possible at edge N+3.
- Throughput: one instruction per 3 cycles (non-flag) or 4 cycles (flag).
- Operand hazard: Vx/Vy are latched at accept, so back-to-back instructions see all prior writes because issue waits for IDLE.
- Debug read latency is 1 cycle. A write at edge E is visible on dbg_data at edge E+1.
- Reset asserted mid-instruction: immediate abort, no further writes, no done; registers cleared asynchronously.

## Configuration
- CHIP8_SHIFT_VY_EN defined: 8xy6/8xyE shift Vy and write the result to Vx (original COSMAC semantics); the flag comes from Vy's bit.
- CHIP8_SHIFT_VY_EN undefined: 8xy6/8xyE shift Vx in place; y is ignored.

## Test plan
- Reset, then 6A3C → after done, VA=0x3C, VF=0, illegal=0; dbg_addr1=A gives 0x3C one cycle later.
- V1=0xF0, V2=0x20, 8124 → V1=0x10, VF=1, done at accept+2; then 8125 with V1=0x10, V2=0x20 → V1=0xF0, VF=0.
- V3=0x81, 8306 → V3=0x40, VF=1 (macro undefined). With the macro and V0=0x03, 8306 → V3=0x01, VF=1.
- VF=0xFF, VE=0x01, 8FE4 → VF=0x01 (flag overwrites result); 7FFF with VF=0x02 → VF=0x01, no further flag write.
- 8128 and 5120 → done with illegal=1, no register changes, done at accept+1.
- Pulse cpu_rst_n low in EXEC of 8124 → all registers 0, no done, instr_ready=1 after release; an instr_valid held during busy cycles is not double-executed.

Source files
------------

// File: rtl/chip8_reg_exec.sv
// Chip-8 V-register file plus load/ALU executor (6xkk, 7xkk, 8xy0-8xyE) with VF flag writeback.
// Build option CHIP8_SHIFT_VY_EN: 8xy6/8xyE shift Vy into Vx instead of shifting Vx in place.
module chip8_reg_exec #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic              illegal,
    input  logic [3:0]        dbg_addr1,
    input  logic [3:0]        dbg_addr2,
    output logic [DATA_W-1:0] dbg_data1,
    output logic [DATA_W-1:0] dbg_data2
);
    // Handshake: an instruction transfers on a rising edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, so nothing queues.
    localparam logic [3:0] FLAG_IDX = 4'(NREGS - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FLAG, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        op_q, op_d, x_q, x_d;
    logic [7:0]        kk_q, kk_d;
    logic [DATA_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic              illegal_q, illegal_d, flag_q, flag_d;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] dbg_data1_q, dbg_data1_d, dbg_data2_q, dbg_data2_d;

    logic              legal_op, idx_ok;
    logic [DATA_W-1:0] res, shift_src;
    logic              flg, flag_op;
    logic [DATA_W:0]   sum;

    // Legality is decided at accept so EXEC only has to consult one bit.
    always_comb begin
        legal_op = 1'b0;
        case (instr[15:12])
            4'h6, 4'h7: legal_op = 1'b1;
            4'h8: legal_op = (instr[3:0] <= 4'h7) || (instr[3:0] == 4'hE);
            default: legal_op = 1'b0;
        endcase
        idx_ok = (32'(instr[11:8]) < NREGS) &&
                 ((instr[15:12] != 4'h8) || (32'(instr[7:4]) < NREGS));
    end

    assign sum = {1'b0, vx_q} + {1'b0, vy_q};
`ifdef CHIP8_SHIFT_VY_EN
    assign shift_src = vy_q;
`else
    assign shift_src = vx_q;
`endif

    always_comb begin
        res     = vx_q;
        flg     = 1'b0;
        flag_op = 1'b0;
        case (op_q)
            4'h6: res = DATA_W'(kk_q);
            4'h7: res = vx_q + DATA_W'(kk_q);
            4'h8: begin
                case (kk_q[3:0])
                    4'h0: res = vy_q;
                    4'h1: res = vx_q | vy_q;
                    4'h2: res = vx_q & vy_q;
                    4'h3: res = vx_q ^ vy_q;
                    4'h4: begin res = sum[DATA_W-1:0]; flg = sum[DATA_W];   flag_op = 1'b1; end
                    4'h5: begin res = vx_q - vy_q;     flg = (vx_q >= vy_q); flag_op = 1'b1; end
                    4'h6: begin res = shift_src >> 1;  flg = shift_src[0];   flag_op = 1'b1; end
                    4'h7: begin res = vy_q - vx_q;     flg = (vy_q >= vx_q); flag_op = 1'b1; end
                    4'hE: begin res = shift_src << 1;  flg = shift_src[DATA_W-1]; flag_op = 1'b1; end
                    default: res = vx_q;
                endcase
            end
            default: res = vx_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        x_d       = x_q;
        kk_d      = kk_q;
        vx_d      = vx_q;
        vy_d      = vy_q;
        illegal_d = illegal_q;
        flag_d    = flag_q;
        regs_d    = regs_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d      = instr[15:12];
                    x_d       = instr[11:8];
                    kk_d      = instr[7:0];
                    vx_d      = (32'(instr[11:8]) < NREGS) ? regs_q[instr[11:8]] : '0;
                    vy_d      = (32'(instr[7:4]) < NREGS) ? regs_q[instr[7:4]] : '0;
                    illegal_d = !(legal_op && idx_ok);
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!illegal_q) begin
                    regs_d[x_q] = res;
                end
                flag_d  = flg;
                state_d = (!illegal_q && flag_op) ? S_FLAG : S_DONE;
            end
            // Flag lands after the result, so x == flag index ends up holding the flag.
            S_FLAG: begin
                regs_d[FLAG_IDX] = DATA_W'(flag_q);
                state_d          = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dbg_data1_d = (32'(dbg_addr1) < NREGS) ? regs_q[dbg_addr1] : '0;
        dbg_data2_d = (32'(dbg_addr2) < NREGS) ? regs_q[dbg_addr2] : '0;
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            x_q         <= '0;
            kk_q        <= '0;
            vx_q        <= '0;
            vy_q        <= '0;
            illegal_q   <= 1'b0;
            flag_q      <= 1'b0;
            dbg_data1_q <= '0;
            dbg_data2_q <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            kk_q        <= kk_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            illegal_q   <= illegal_d;
            flag_q      <= flag_d;
            dbg_data1_q <= dbg_data1_d;
            dbg_data2_q <= dbg_data2_d;
            regs_q      <= regs_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_DONE);
    assign illegal     = (state_q == S_DONE) && illegal_q;
    assign dbg_data1   = dbg_data1_q;
    assign dbg_data2   = dbg_data2_q;
endmodule

// File: tb/tb_chip8_reg_exec.sv
// Bench for chip8_reg_exec: directed scenarios plus random instructions against an arithmetic register model.
module tb_chip8_reg_exec;
    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, done, illegal;
    logic [3:0]  dbg_addr1 = '0, dbg_addr2 = '0;
    logic [7:0]  dbg_data1, dbg_data2;

    int errors = 0;
    int checks = 0;
    int mv [16];
    int lat;
    logic ill;
    logic [7:0] d1, d2;
    bit e_ill, e_fop;

    chip8_reg_exec #(.DATA_W(8), .NREGS(16)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .illegal(illegal),
        .dbg_addr1(dbg_addr1), .dbg_addr2(dbg_addr2), .dbg_data1(dbg_data1), .dbg_data2(dbg_data2)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference: Chip-8 semantics on plain integers, register values 0..255.
    function automatic void model_exec(input logic [15:0] ins, output bit m_ill, output bit m_fop);
        int op = int'(ins[15:12]);
        int x = int'(ins[11:8]);
        int y = int'(ins[7:4]);
        int n = int'(ins[3:0]);
        int kk = int'(ins[7:0]);
        int vx = mv[x];
        int vy = mv[y];
        int src, res, f;
        m_ill = 0; m_fop = 0; res = vx; f = 0;
`ifdef CHIP8_SHIFT_VY_EN
        src = vy;
`else
        src = vx;
`endif
        if (op == 6) res = kk;
        else if (op == 7) res = (vx + kk) % 256;
        else if (op == 8) begin
            case (n)
                0: res = vy;
                1: res = vx | vy;
                2: res = vx & vy;
                3: res = vx ^ vy;
                4: begin res = (vx + vy) % 256; f = (vx + vy > 255) ? 1 : 0; m_fop = 1; end
                5: begin res = (vx - vy + 256) % 256; f = (vx >= vy) ? 1 : 0; m_fop = 1; end
                6: begin res = src / 2; f = src % 2; m_fop = 1; end
                7: begin res = (vy - vx + 256) % 256; f = (vy >= vx) ? 1 : 0; m_fop = 1; end
                14: begin res = (src * 2) % 256; f = src / 128; m_fop = 1; end
                default: m_ill = 1;
            endcase
        end else m_ill = 1;
        if (m_ill) m_fop = 0;
        if (!m_ill) begin
            mv[x] = res;
            if (m_fop) mv[15] = f;
        end
    endfunction

    // Issue one instruction; returns cycles from accept edge to done (0 on timeout) and the illegal flag.
    task automatic run_instr(input logic [15:0] ins, input bit hold, output int o_lat, output logic o_ill);
        int w = 0;
        @(negedge cpu_clk);
        while (!instr_ready && w < 10) begin
            @(negedge cpu_clk);
            w++;
        end
        instr = ins;
        instr_valid = 1'b1;
        @(posedge cpu_clk);
        o_lat = 0;
        o_ill = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge cpu_clk);
            if (k == 1 && !hold) instr_valid = 1'b0;
            if (done) begin
                o_lat = k;
                o_ill = illegal;
                break;
            end
        end
        instr_valid = 1'b0;
    endtask

    task automatic read_regs(input logic [3:0] a1, input logic [3:0] a2, output logic [7:0] o1, output logic [7:0] o2);
        @(negedge cpu_clk);
        dbg_addr1 = a1;
        dbg_addr2 = a2;
        @(negedge cpu_clk);
        o1 = dbg_data1;
        o2 = dbg_data2;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge cpu_clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", instr_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        checks++; if (dbg_data1 !== 8'h00) begin errors++; $display("FAIL reset_dbg1 got=%h exp=00", dbg_data1); end
        cpu_rst_n = 1'b1;
        for (int i = 0; i < 16; i++) mv[i] = 0;
        for (int i = 0; i < 16; i += 2) begin
            read_regs(4'(i), 4'(i + 1), d1, d2);
            checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", i, d1); end
            checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got=%h exp=00", i + 1, d2); end
        end
    endtask

    task automatic test_load();
        run_instr(16'h6A3C, 0, lat, ill); model_exec(16'h6A3C, e_ill, e_fop);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got=%0d exp=2", lat); end
        checks++; if (ill !== 1'b0) begin errors++; $display("FAIL load_illegal got=%b exp=0", ill); end
        read_regs(4'hA, 4'hF, d1, d2);
        checks++; if (d1 !== 8'h3C) begin errors++; $display("FAIL load_va got=%h exp=3c", d1); end
        checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL load_vf got=%h exp=00", d2); end
        @(negedge cpu_clk);
        dbg_addr1 = 4'hB;
        run_instr(16'h6B55, 0, lat, ill); model_exec(16'h6B55, e_ill, e_fop);
        checks++; if (dbg_data1 !== 8'h00) begin errors++; $display("FAIL dbg_latency_old got=%h exp=00", dbg_data1); end
        @(negedge cpu_clk);
        checks++; if (dbg_data1 !== 8'h55) begin errors++; $display("FAIL dbg_latency_new got=%h exp=55", dbg_data1); end
    endtask

    task automatic test_add_sub();
        run_instr(16'h61F0, 0, lat, ill); model_exec(16'h61F0, e_ill, e_fop);
        run_instr(16'h6220, 0, lat, ill); model_exec(16'h6220, e_ill, e_fop);
        run_instr(16'h8124, 0, lat, ill); model_exec(16'h8124, e_ill, e_fop);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency got=%0d exp=3", lat); end
        read_regs(4'h1, 4'hF, d1, d2);
        checks++; if (d1 !== 8'h10) begin errors++; $display("FAIL add_v1 got=%h exp=10", d1); end
        checks++; if (d2 !== 8'h01) begin errors++; $display("FAIL add_vf got=%h exp=01", d2); end
        run_instr(16'h8125, 0, lat, ill); model_exec(16'h8125, e_ill, e_fop);
        read_regs(4'h1, 4'hF, d1, d2);
        checks++; if (d1 !== 8'hF0) begin errors++; $display("FAIL sub_v1 got=%h exp=f0", d1); end
        checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL sub_vf got=%h exp=00", d2); end
    endtask

    task automatic test_shift();
        logic [7:0] exp_v3;
`ifdef CHIP8_SHIFT_VY_EN
        exp_v3 = 8'h01;
`else
        exp_v3 = 8'h40;
`endif
        run_instr(16'h6381, 0, lat, ill); model_exec(16'h6381, e_ill, e_fop);
        run_instr(16'h6003, 0, lat, ill); model_exec(16'h6003, e_ill, e_fop);
        run_instr(16'h8306, 0, lat, ill); model_exec(16'h8306, e_ill, e_fop);
        read_regs(4'h3, 4'hF, d1, d2);
        checks++; if (d1 !== exp_v3) begin errors++; $display("FAIL shr_v3 got=%h exp=%h", d1, exp_v3); end
        checks++; if (d2 !== 8'h01) begin errors++; $display("FAIL shr_vf got=%h exp=01", d2); end
    endtask

    task automatic test_flag_overwrite();
        run_instr(16'h6FFF, 0, lat, ill); model_exec(16'h6FFF, e_ill, e_fop);
        run_instr(16'h6E01, 0, lat, ill); model_exec(16'h6E01, e_ill, e_fop);
        run_instr(16'h8FE4, 0, lat, ill); model_exec(16'h8FE4, e_ill, e_fop);
        read_regs(4'hF, 4'hE, d1, d2);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL ovr_vf got=%h exp=01", d1); end
        run_instr(16'h6F02, 0, lat, ill); model_exec(16'h6F02, e_ill, e_fop);
        run_instr(16'h7FFF, 0, lat, ill); model_exec(16'h7FFF, e_ill, e_fop);
        checks++; if (lat !== 2) begin errors++; $display("FAIL addi_latency got=%0d exp=2", lat); end
        read_regs(4'hF, 4'hE, d1, d2);
        checks++; if (d1 !== 8'h01) begin errors++; $display("FAIL addi_vf got=%h exp=01", d1); end
    endtask

    task automatic test_illegal();
        logic [15:0] bad [2];
        bad[0] = 16'h8128;
        bad[1] = 16'h5120;
        for (int i = 0; i < 2; i++) begin
            run_instr(bad[i], 0, lat, ill); model_exec(bad[i], e_ill, e_fop);
            checks++; if (lat !== 2) begin errors++; $display("FAIL illegal_latency%0d got=%0d exp=2", i, lat); end
            checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag%0d got=%b exp=1", i, ill); end
            read_regs(4'h1, 4'h2, d1, d2);
            checks++; if (d1 !== 8'(mv[1])) begin errors++; $display("FAIL illegal_v1_%0d got=%h exp=%h", i, d1, 8'(mv[1])); end
            checks++; if (d2 !== 8'(mv[2])) begin errors++; $display("FAIL illegal_v2_%0d got=%h exp=%h", i, d2, 8'(mv[2])); end
        end
    endtask

    task automatic test_held_valid();
        run_instr(16'h6105, 0, lat, ill); model_exec(16'h6105, e_ill, e_fop);
        run_instr(16'h7101, 1, lat, ill); model_exec(16'h7101, e_ill, e_fop);
        checks++; if (lat !== 2) begin errors++; $display("FAIL held_latency got=%0d exp=2", lat); end
        repeat (3) @(negedge cpu_clk);
        read_regs(4'h1, 4'hF, d1, d2);
        checks++; if (d1 !== 8'h06) begin errors++; $display("FAIL held_v1 got=%h exp=06", d1); end
    endtask

    task automatic test_reset_mid();
        run_instr(16'h61F0, 0, lat, ill); model_exec(16'h61F0, e_ill, e_fop);
        run_instr(16'h6220, 0, lat, ill); model_exec(16'h6220, e_ill, e_fop);
        @(negedge cpu_clk);
        instr = 16'h8124;
        instr_valid = 1'b1;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        instr_valid = 1'b0;
        cpu_rst_n = 1'b0;
        for (int i = 0; i < 16; i++) mv[i] = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge cpu_clk);
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done%0d got=%b exp=0", k, done); end
        end
        cpu_rst_n = 1'b1;
        #1;
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", instr_ready); end
        for (int i = 0; i < 16; i += 2) begin
            read_regs(4'(i), 4'(i + 1), d1, d2);
            checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d got=%h exp=00", i, d1); end
            checks++; if (d2 !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d got=%h exp=00", i + 1, d2); end
        end
    endtask

    task automatic test_random();
        logic [15:0] ins;
        int kind, top, exp_lat;
        for (int t = 0; t < 80; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) ins = {4'h6, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            else if (kind < 4) ins = {4'h7, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255))};
            else if (kind < 9) ins = {4'h8, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            else begin
                top = $urandom_range(0, 15);
                if (top >= 6 && top <= 8) top = 5;
                ins = {4'(top), 12'($urandom_range(0, 4095))};
            end
            run_instr(ins, 0, lat, ill); model_exec(ins, e_ill, e_fop);
            exp_lat = e_fop ? 3 : 2;
            checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency ins=%h got=%0d exp=%0d", ins, lat, exp_lat); end
            checks++; if (ill !== e_ill) begin errors++; $display("FAIL rnd_illegal ins=%h got=%b exp=%b", ins, ill, e_ill); end
            read_regs(ins[11:8], 4'hF, d1, d2);
            checks++; if (d1 !== 8'(mv[ins[11:8]])) begin errors++; $display("FAIL rnd_vx ins=%h got=%h exp=%h", ins, d1, 8'(mv[ins[11:8]])); end
            checks++; if (d2 !== 8'(mv[15])) begin errors++; $display("FAIL rnd_vf ins=%h got=%h exp=%h", ins, d2, 8'(mv[15])); end
        end
        for (int i = 0; i < 16; i += 2) begin
            read_regs(4'(i), 4'(i + 1), d1, d2);
            checks++; if (d1 !== 8'(mv[i])) begin errors++; $display("FAIL rnd_final_reg%0d got=%h exp=%h", i, d1, 8'(mv[i])); end
            checks++; if (d2 !== 8'(mv[i + 1])) begin errors++; $display("FAIL rnd_final_reg%0d got=%h exp=%h", i + 1, d2, 8'(mv[i + 1])); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_add_sub();
        test_shift();
        test_flag_overwrite();
        test_illegal();
        test_held_valid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
